// File: rtl/rr_arb_pkg.sv
// Shared types and sizes for the four-way round-robin output arbiter.
// Imported by mux_4_1 and rr_mux_arbiter_4.
package rr_arb_pkg;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 4;

  typedef logic [1:0]        req_id_t;
  typedef logic [DATA_W-1:0] data_t;

  // Round-robin successor; the 2-bit width makes 3 wrap to 0.
  function automatic req_id_t next_id(input req_id_t id);
    return id + req_id_t'(1);
  endfunction

endpackage : rr_arb_pkg

// File: rtl/mux_4_1.sv
// Four-to-one payload select; the arbiter drives sel with the winner index.
module mux_4_1
  import rr_arb_pkg::*;
(
  input  req_id_t sel,
  input  data_t   d0,
  input  data_t   d1,
  input  data_t   d2,
  input  data_t   d3,
  output data_t   y
);

  // NOTE: every path through an always_comb assigns y, so no latch is inferred.
  always_comb begin
    unique case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule : mux_4_1

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter sharing one registered 4-bit output slot among four
// valid/ready requesters. Optional grant counters behind RR_ARB_STATS_EN.
module rr_mux_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int CNT_W = 8
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  input  data_t            req_data0,
  input  data_t            req_data1,
  input  data_t            req_data2,
  input  data_t            req_data3,
  output logic [N_REQ-1:0] req_ready,
  output logic             out_valid,
  output data_t            out_data,
  output req_id_t          out_id,
  input  logic             out_ready
`ifdef RR_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_cnt0,
  output logic [CNT_W-1:0] stat_cnt1,
  output logic [CNT_W-1:0] stat_cnt2,
  output logic [CNT_W-1:0] stat_cnt3
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("rr_mux_arbiter_4: CNT_W must be at least 1");
  end

  logic    out_valid_q, out_valid_d;
  data_t   out_data_q,  out_data_d;
  req_id_t out_id_q,    out_id_d;
  req_id_t ptr_q,       ptr_d;

  logic    load_en;
  logic    any_valid;
  logic    found;
  req_id_t scan_idx;
  req_id_t winner;
  data_t   winner_data;

  // The slot may refill on the same edge its current word is drained.
  assign load_en   = !out_valid_q || out_ready;
  assign any_valid = |req_valid;

  always_comb begin
    winner   = ptr_q;
    found    = 1'b0;
    scan_idx = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = ptr_q + req_id_t'(k);
      if (!found && req_valid[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  mux_4_1 u_data_sel (
    .sel (winner),
    .d0  (req_data0),
    .d1  (req_data1),
    .d2  (req_data2),
    .d3  (req_data3),
    .y   (winner_data)
  );

  // Ready is gated by rst so no handshake can be seen during reset.
  always_comb begin
    req_ready = '0;
    if (!rst && load_en && any_valid) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (any_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = winner_data;
        out_id_d    = winner;
        ptr_d       = next_id(winner);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

`ifdef RR_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];

  // Saturating per-requester grant counters.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (req_valid[i] && req_ready[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign stat_cnt0 = cnt_q[0];
  assign stat_cnt1 = cnt_q[1];
  assign stat_cnt2 = cnt_q[2];
  assign stat_cnt3 = cnt_q[3];
`endif

  a_ready_onehot0 : assert property (@(posedge clk) $onehot0(req_ready));

  a_hold_under_backpressure : assert property (
    @(posedge clk) disable iff (rst)
    (out_valid_q && !out_ready) |=> ($stable(out_data_q) && $stable(out_id_q)));

endmodule : rr_mux_arbiter_4

// File: tb/tb_rr_mux_arbiter_4.sv
// Directed self-checking bench for rr_mux_arbiter_4; compile with
// RR_ARB_STATS_EN defined to also exercise the grant counters (CNT_W = 2).
module tb_rr_mux_arbiter_4;
  import rr_arb_pkg::*;

`ifdef RR_ARB_STATS_EN
  localparam int TB_CNT_W = 2;
`else
  localparam int TB_CNT_W = 8;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [N_REQ-1:0] req_valid;
  data_t            req_data0, req_data1, req_data2, req_data3;
  logic [N_REQ-1:0] req_ready;
  logic             out_valid;
  data_t            out_data;
  req_id_t          out_id;
  logic             out_ready;
`ifdef RR_ARB_STATS_EN
  logic [TB_CNT_W-1:0] stat_cnt0, stat_cnt1, stat_cnt2, stat_cnt3;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter_4 #(.CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_data2 (req_data2),
    .req_data3 (req_data3),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
`ifdef RR_ARB_STATS_EN
    ,
    .stat_cnt0 (stat_cnt0),
    .stat_cnt1 (stat_cnt1),
    .stat_cnt2 (stat_cnt2),
    .stat_cnt3 (stat_cnt3)
`endif
  );

  // Leaves the bench at a falling edge with reset released and inputs idle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 4'b0000; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 4'b1111; out_ready = 1'b1;
    req_data0 = 4'h1; req_data1 = 4'h2; req_data2 = 4'h3; req_data3 = 4'h4;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests_run++;
      if (req_ready !== 4'b0000) begin
        tests_failed++;
        $display("FAIL reset_ready cyc%0d: got %b want 0000", c, req_ready);
      end
      @(negedge clk);
    end
    rst = 1'b0; req_valid = 4'b0000;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_id !== 2'd0 || out_data !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%b id=%0d d=%h want v=0 id=0 d=0",
               out_valid, out_id, out_data);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_data2 = 4'hA; out_ready = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 4'b0100) begin
      tests_failed++;
      $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== 4'hA) begin
      tests_failed++;
      $display("FAIL single_out: got v=%b id=%0d d=%h want v=1 id=2 d=a",
               out_valid, out_id, out_data);
    end
    @(negedge clk);
    req_valid = 4'b0000;
  endtask

  task automatic test_rotation();
    logic [3:0] exp_rdy [5];
    req_id_t    exp_id  [5];
    data_t      exp_d   [5];
    exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_d   = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
    do_reset();
    req_data0 = 4'h1; req_data1 = 4'h2; req_data2 = 4'h3; req_data3 = 4'h4;
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests_run++;
      if (req_ready !== exp_rdy[k]) begin
        tests_failed++;
        $display("FAIL rot_ready[%0d]: got %b want %b", k, req_ready, exp_rdy[k]);
      end
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_id !== exp_id[k] || out_data !== exp_d[k]) begin
        tests_failed++;
        $display("FAIL rot_out[%0d]: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                 k, out_valid, out_id, out_data, exp_id[k], exp_d[k]);
      end
      @(negedge clk);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0010; req_data1 = 4'h6; out_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'b1000; req_data3 = 4'h7; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if (req_ready !== 4'b0000) begin
        tests_failed++;
        $display("FAIL bp_ready cyc%0d: got %b want 0000", c, req_ready);
      end
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 4'h6) begin
        tests_failed++;
        $display("FAIL bp_hold cyc%0d: got v=%b id=%0d d=%h want v=1 id=1 d=6",
                 c, out_valid, out_id, out_data);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 4'b1000) begin
      tests_failed++;
      $display("FAIL bp_release_ready: got %b want 1000", req_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== 4'h7) begin
      tests_failed++;
      $display("FAIL bp_release_out: got v=%b id=%0d d=%h want v=1 id=3 d=7",
               out_valid, out_id, out_data);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_id !== 2'd3 || out_data !== 4'h7) begin
      tests_failed++;
      $display("FAIL drain_idle: got v=%b id=%0d d=%h want v=0 id=3 d=7",
               out_valid, out_id, out_data);
    end
    @(negedge clk);
  endtask

  // Pointer walk: grant 3 -> ptr 0; 0011 -> 0; 0010 -> 1; 1001 -> 3 then 0.
  task automatic test_wrap_skip();
    logic [3:0] vec     [5];
    logic [3:0] exp_rdy [5];
    req_id_t    exp_id  [5];
    vec     = '{4'b1000, 4'b0011, 4'b0010, 4'b1001, 4'b0001};
    exp_rdy = '{4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001};
    exp_id  = '{2'd3, 2'd0, 2'd1, 2'd3, 2'd0};
    do_reset();
    req_data0 = 4'hC; req_data1 = 4'hD; req_data2 = 4'hE; req_data3 = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req_valid = vec[k];
      #1;
      tests_run++;
      if (req_ready !== exp_rdy[k]) begin
        tests_failed++;
        $display("FAIL wrap_ready[%0d]: got %b want %b", k, req_ready, exp_rdy[k]);
      end
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_id !== exp_id[k]) begin
        tests_failed++;
        $display("FAIL wrap_id[%0d]: got v=%b id=%0d want v=1 id=%0d",
                 k, out_valid, out_id, exp_id[k]);
      end
      @(negedge clk);
    end
    req_valid = 4'b0000;
  endtask

`ifdef RR_ARB_STATS_EN
  task automatic test_stats();
    logic [TB_CNT_W-1:0] exp_c0 [5];
    exp_c0 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    req_valid = 4'b0001; req_data0 = 4'h5; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (stat_cnt0 !== exp_c0[k] || stat_cnt1 !== '0 || stat_cnt2 !== '0 ||
          stat_cnt3 !== '0) begin
        tests_failed++;
        $display("FAIL stats[%0d]: got %0d/%0d/%0d/%0d want %0d/0/0/0",
                 k, stat_cnt0, stat_cnt1, stat_cnt2, stat_cnt3, exp_c0[k]);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (stat_cnt0 !== '0 || stat_cnt1 !== '0 || stat_cnt2 !== '0 ||
        stat_cnt3 !== '0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stats_reset: got %0d/%0d/%0d/%0d v=%b want 0/0/0/0 v=0",
               stat_cnt0, stat_cnt1, stat_cnt2, stat_cnt3, out_valid);
    end
    @(negedge clk);
    rst = 1'b0; req_valid = 4'b0000;
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = 4'b0000; out_ready = 1'b0;
    req_data0 = 4'h0; req_data1 = 4'h0; req_data2 = 4'h0; req_data3 = 4'h0;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_wrap_skip();
`ifdef RR_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_rr_mux_arbiter_4

// File: doc/rr_mux_arbiter_4.md
# rr_mux_arbiter_4

Round-robin arbiter that shares one 4-bit output channel between four valid/ready requesters. Each cycle it picks one requester, steers that requester's data through the 4:1 data select, and captures it in a one-entry output register. It sits between four independent producers and a single consumer, and drives the mux select so that no requester starves.

## Interface
Parameters:
- `CNT_W`, default 8: width of each per-requester grant counter. Used only when `RR_ARB_STATS_EN` is defined.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `req_valid`  input  4  request valid, bit i belongs to requester i.
- `req_data0`..`req_data3`  input  4 each  requester payloads.
- `req_ready`  output  4  accept strobe, one-hot or zero.
- `out_valid`  output  1  output register holds a word.
- `out_data`  output  4  registered payload.
- `out_id`  output  2  index of the requester that supplied `out_data`.
- `out_ready`  input  1  consumer accepts the word.
- `stat_cnt0`..`stat_cnt3`  output  `CNT_W` each  grant counters. Present only with `RR_ARB_STATS_EN`.

## Operation
- Internal state:
  - `ptr` [1:0]: the highest-priority requester index.
  - The output slot: `out_valid`, `out_data`, `out_id`.
- `load_en = !out_valid || out_ready`. The slot can take a new word in the same cycle the old word leaves.
- Winner selection, combinational:
  - Scan indices ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - The winner is the first index with `req_valid` set.
- `req_ready[i] = load_en && any(req_valid) && (i == winner)`. All other bits are 0.
- On a clock edge with `load_en` and any valid request:
  - `out_data` takes the winner's payload, selected through the 4:1 mux using the winner as the select.
  - `out_id` takes the winner index.
  - `out_valid` goes to 1.
  - `ptr` takes (winner + 1) mod 4, with 3 wrapping to 0.
- On a clock edge with `load_en` and no valid request:
  - `out_valid` goes to 0.
  - `out_data`, `out_id` and `ptr` hold.
- On a clock edge with `!load_en` (slot full and `out_ready` low), all state holds and `req_ready` is 0.
- Requester rules:
  - Once `req_valid` is asserted, `req_valid` and the payload stay stable until the handshake completes.
  - `req_valid` must not depend combinationally on `req_ready`.
- `req_ready` depends combinationally on `req_valid` and `out_ready`. The design has no registered ready.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 4'h0, `out_id` = 2'd0, `ptr` = 0. All counters are 0.
- `req_ready` is 0 during reset.
- Latency: a request accepted in cycle N appears on `out_valid`/`out_data` in cycle N+1.
- Throughput: one word per cycle while `out_ready` is held high.
- Simultaneous drain and load: the slot is replaced in one edge, with no bubble.
- Backpressure: while the slot is full and `out_ready` is low, `out_data` and `out_id` stay frozen.
- Reset mid-operation: a word pending in the slot is discarded and `ptr` returns to 0. A handshake that coincides with the reset cycle does not count.
- Fairness: a continuously valid requester is granted within at most 4 accepts.

## Configuration
- Macro: `RR_ARB_STATS_EN`.
- When defined:
  - Four `CNT_W`-bit counters are compiled in.
  - Counter i increments on each cycle in which `req_valid[i] && req_ready[i]`.
  - Counters saturate at 2^`CNT_W`-1 and reset to 0.
  - The counters are exposed on `stat_cnt0`..`stat_cnt3`.
- When not defined: no counter logic and no `stat_cnt*` ports. All other behaviour is identical.

## Structure
- Package `rr_arb_pkg` holds:
  - `N_REQ` = 4 and `DATA_W` = 4.
  - `typedef logic [1:0] req_id_t;`
  - `typedef logic [DATA_W-1:0] data_t;`
- Sub-module: the existing `mux_4_1` is instantiated as the data select. Its `sel` is the winner index.
- The winner scan and the pointer update stay inline in `rr_mux_arbiter_4`.

## Test plan
- **Reset:** hold `rst` for 2 cycles with all `req_valid` = 4'b1111.
  - During reset: `req_ready` = 0.
  - After release: `out_valid` = 0, `out_id` = 0, `out_data` = 0.
- **Single requester:** only `req_valid[2]`, `req_data2` = 4'hA, `out_ready` = 1.
  - `req_ready` = 4'b0100 in that cycle.
  - Next cycle: `out_valid` = 1, `out_id` = 2, `out_data` = 4'hA.
- **Full contention rotation:** `req_valid` = 4'b1111 constantly, payloads 1/2/3/4, `out_ready` = 1.
  - `out_id` sequence is 0,1,2,3,0.
  - `out_data` sequence is 1,2,3,4,1.
- **Backpressure:** the slot holds id 1, `out_ready` = 0 for 3 cycles, requester 3 is valid.
  - `req_ready` = 0 and `out_data` is stable throughout.
  - When `out_ready` rises, requester 3 is accepted in the same cycle and appears the following cycle.
- **Pointer wrap and skip:**
  - After a grant to 3, `ptr` = 0.
  - With `req_valid` = 4'b0010, the grant goes to 1.
  - With `req_valid` = 4'b1001 and `ptr` = 2, the grant goes to 3 and then to 0.
- **Stats (with `RR_ARB_STATS_EN`, `CNT_W` = 2):** 5 accepts from requester 0.
  - `stat_cnt0` reads 1,2,3,3,3.
  - The other counters stay at 0.
  - A reset clears all counters.
